vga_capture: RTL and testbench



---
 rtl/vga_capture.sv | 163 ++++++++++++++++
 tb/tb_vga_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Receive-side VGA timing checker and pixel recoverer. Samples the generator's
// pixel clock as data on CLOCK_50, verifies line/frame timing, then emits active pixels.
module vga_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       vga_clk,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [7:0] vga_r,
    input  logic [7:0] vga_g,
    input  logic [7:0] vga_b,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [1:0] pix_r,
    output logic [1:0] pix_g,
    output logic [1:0] pix_b,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_RISE  = 10'(H_SYNC);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_RISE  = 10'(V_SYNC);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t     state;
    logic       s1_clk, s1_hs, s1_vs;
    logic [1:0] s1_r, s1_g, s1_b;
    logic       s2_clk, s2_hs, s2_vs;
    logic       hs_prev, vs_prev;
    logic [9:0] hcount, vcount;

    // Only the top two colour bits are recovered; the rest of the bus is intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{vga_r[5:0], vga_g[5:0], vga_b[5:0], s2_hs, s2_vs};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            s1_clk <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            s2_clk <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else begin
            s1_clk <= vga_clk;
            s1_hs  <= vga_hs;
            s1_vs  <= vga_vs;
            s1_r   <= vga_r[7:6];
            s1_g   <= vga_g[7:6];
            s1_b   <= vga_b[7:6];
            s2_clk <= s1_clk;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    logic       strobe, hs_fall, hs_rise, vs_fall, vs_rise;
    logic [9:0] hcount_next, vcount_next;
    logic       check_fail, active;

    assign strobe  = s1_clk & ~s2_clk;
    assign hs_fall = ~s1_hs &  hs_prev;
    assign hs_rise =  s1_hs & ~hs_prev;
    assign vs_fall = ~s1_vs &  vs_prev;
    assign vs_rise =  s1_vs & ~vs_prev;

    assign hcount_next = hs_fall ? '0 : hcount + 10'd1;
    assign vcount_next = (vs_fall && hs_fall) ? '0 :
                         hs_fall              ? vcount + 10'd1 : vcount;

    // Fall checks look at the count that just ended; rise checks at the freshly updated count.
    assign check_fail = (hs_fall && hcount != H_LAST)
                     || (hs_rise && hcount_next != H_RISE)
                     || (vs_fall && (vcount != V_LAST || !hs_fall))
                     || (vs_rise && vcount_next != V_RISE);

    assign active = (hcount_next >= H_START) && (hcount_next < H_END)
                 && (vcount_next >= V_START) && (vcount_next < V_END);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state       <= SEARCH;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hcount      <= '0;
            vcount      <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            err_count   <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (strobe) begin
                hs_prev <= s1_hs;
                vs_prev <= s1_vs;
                hcount  <= hcount_next;
                vcount  <= vcount_next;
                case (state)
                    SEARCH: begin
                        if (vs_fall) state <= VERIFY;
                    end
                    VERIFY: begin
                        if (check_fail) begin
                            state <= SEARCH;
                        end else if (vs_fall) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // A failing strobe drops lock and never yields a pixel.
                        if (check_fail) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end else if (active) begin
                            pix_valid   <= 1'b1;
                            pix_x       <= hcount_next - H_START;
                            pix_y       <= vcount_next - V_START;
                            pix_r       <= s1_r;
                            pix_g       <= s1_g;
                            pix_b       <= s1_b;
                            frame_start <= (hcount_next == H_START) && (vcount_next == V_START);
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a miniature VGA generator drives the DUT while a scoreboard
// queue holds the pixels each locked frame should yield; frame-level outcomes come from a table.
module tb_vga_capture;

    localparam int H_SYNC   = 2;
    localparam int H_BACK   = 1;
    localparam int H_ACTIVE = 4;
    localparam int H_TOTAL  = 8;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 1;
    localparam int V_ACTIVE = 2;
    localparam int V_TOTAL  = 5;
    localparam int H_START  = H_SYNC + H_BACK;
    localparam int V_START  = V_SYNC + V_BACK;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam logic [7:0] G_LEVEL = 8'hC5;
    localparam logic [7:0] B_LEVEL = 8'h7A;

    logic       CLOCK_50;
    logic       reset;
    logic       vga_clk, vga_hs, vga_vs;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       pix_valid, frame_start, locked;
    logic [9:0] pix_x, pix_y;
    logic [1:0] pix_r, pix_g, pix_b;
    logic [7:0] err_count;

    vga_capture #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked), .err_count(err_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       fs;
    } pix_t;

    typedef struct {
        bit         cap;
        int         bad_line;
        int         bad_len;
        int         bad_hs;
        logic       exp_locked;
        logic [7:0] exp_err;
        int         exp_pix;
    } frame_vec_t;

    pix_t exp_q[$];
    int   checks;
    int   errors;
    int   pix_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every negedge passes through here, so outputs are sampled away from the active edge.
    task automatic tick();
        pix_t e;
        @(negedge CLOCK_50);
        if (pix_valid === 1'b1) begin
            pix_seen++;
            if (exp_q.size() == 0) begin
                check("spurious pix_valid", 32'(pix_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_x", 32'(pix_x), 32'(e.x));
                check("pix_y", 32'(pix_y), 32'(e.y));
                check("pix_r", 32'(pix_r), 32'(e.r));
                check("pix_g", 32'(pix_g), 32'(e.g));
                check("pix_b", 32'(pix_b), 32'(e.b));
                check("frame_start", 32'(frame_start), 32'(e.fs));
            end
        end else if (frame_start !== 1'b0) begin
            check("frame_start without pix_valid", 32'(frame_start), 32'd0);
        end
    endtask

    task automatic gen_pixel(input int h, input int v, input int hs_w, input bit cap);
        logic [9:0] x, y;
        pix_t e;
        x = 10'(h - H_START);
        y = 10'(v - V_START);
        if (cap && h >= H_START && h < H_START + H_ACTIVE && v >= V_START && v < V_START + V_ACTIVE) begin
            e.x  = x;
            e.y  = y;
            e.r  = x[1:0];
            e.g  = G_LEVEL[7:6];
            e.b  = B_LEVEL[7:6];
            e.fs = (x == 10'd0) && (y == 10'd0);
            exp_q.push_back(e);
        end
        tick();
        vga_clk = 1'b1;
        vga_hs  = (h >= hs_w);
        vga_vs  = (v >= V_SYNC);
        vga_r   = {x[1:0], 6'b0};
        vga_g   = G_LEVEL;
        vga_b   = B_LEVEL;
        tick();
        vga_clk = 1'b0;
    endtask

    task automatic gen_line(input int v, input int len, input int hs_w, input bit cap);
        for (int h = 0; h < len; h++) gen_pixel(h, v, hs_w, cap);
    endtask

    // Pixels are expected only up to the altered line; the next HS fall drops lock.
    task automatic gen_frame(input bit cap, input int bad_line, input int bad_len, input int bad_hs);
        for (int v = 0; v < V_TOTAL; v++) begin
            if (v == bad_line) gen_line(v, bad_len, bad_hs, cap);
            else               gen_line(v, H_TOTAL, H_SYNC, cap && (bad_line < 0 || v <= bad_line));
        end
    endtask

    frame_vec_t vecs[7];
    int         base;

    initial begin
        checks   = 0;
        errors   = 0;
        pix_seen = 0;

        vecs[0] = '{cap: 0, bad_line: 1,  bad_len: H_TOTAL,     bad_hs: H_SYNC - 1, exp_locked: 0, exp_err: 8'd0, exp_pix: 0};
        vecs[1] = '{cap: 0, bad_line: -1, bad_len: H_TOTAL,     bad_hs: H_SYNC,     exp_locked: 0, exp_err: 8'd0, exp_pix: 0};
        vecs[2] = '{cap: 1, bad_line: -1, bad_len: H_TOTAL,     bad_hs: H_SYNC,     exp_locked: 1, exp_err: 8'd0, exp_pix: FRAME_PIX};
        vecs[3] = '{cap: 1, bad_line: -1, bad_len: H_TOTAL,     bad_hs: H_SYNC,     exp_locked: 1, exp_err: 8'd0, exp_pix: FRAME_PIX};
        vecs[4] = '{cap: 1, bad_line: 3,  bad_len: H_TOTAL + 1, bad_hs: H_SYNC,     exp_locked: 0, exp_err: 8'd1, exp_pix: FRAME_PIX};
        vecs[5] = '{cap: 0, bad_line: -1, bad_len: H_TOTAL,     bad_hs: H_SYNC,     exp_locked: 0, exp_err: 8'd1, exp_pix: 0};
        vecs[6] = '{cap: 1, bad_line: -1, bad_len: H_TOTAL,     bad_hs: H_SYNC,     exp_locked: 1, exp_err: 8'd1, exp_pix: FRAME_PIX};

        reset   = 1'b0;
        vga_clk = 1'b0;
        vga_hs  = 1'b1;
        vga_vs  = 1'b1;
        vga_r   = '0;
        vga_g   = '0;
        vga_b   = '0;
        repeat (3) tick();
        check("reset pix_valid", 32'(pix_valid), 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset locked", 32'(locked), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check("reset pix_x", 32'(pix_x), 32'd0);
        check("reset pix_y", 32'(pix_y), 32'd0);
        check("reset rgb", 32'({pix_r, pix_g, pix_b}), 32'd0);
        reset = 1'b1;

        // Join mid-frame: no lock possible before a VS fall.
        for (int v = 2; v < V_TOTAL; v++) gen_line(v, H_TOTAL, H_SYNC, 1'b0);
        check("locked after partial frame", 32'(locked), 32'd0);

        for (int i = 0; i < 7; i++) begin
            base = pix_seen;
            gen_frame(vecs[i].cap, vecs[i].bad_line, vecs[i].bad_len, vecs[i].bad_hs);
            check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].exp_locked));
            check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d pixel count", i), 32'(pix_seen - base), 32'(vecs[i].exp_pix));
            check($sformatf("vec%0d scoreboard drained", i), 32'(exp_q.size()), 32'd0);
        end

        // Line 2 one pixel short: lock drops one cycle after the next HS fall.
        base = pix_seen;
        gen_line(0, H_TOTAL, H_SYNC, 1'b1);
        gen_line(1, H_TOTAL, H_SYNC, 1'b1);
        gen_line(2, H_TOTAL - 1, H_SYNC, 1'b1);
        gen_pixel(0, 3, H_SYNC, 1'b0);
        check("locked before failing strobe", 32'(locked), 32'd1);
        tick();
        check("locked after short line", 32'(locked), 32'd0);
        check("err_count after short line", 32'(err_count), 32'd2);
        for (int h = 1; h < H_TOTAL; h++) gen_pixel(h, 3, H_SYNC, 1'b0);
        gen_line(4, H_TOTAL, H_SYNC, 1'b0);
        check("pixels before short-line failure", 32'(pix_seen - base), 32'(H_ACTIVE));
        gen_frame(1'b0, -1, H_TOTAL, H_SYNC);
        check("locked during reverify", 32'(locked), 32'd0);
        gen_frame(1'b1, -1, H_TOTAL, H_SYNC);
        check("relocked after short line", 32'(locked), 32'd1);
        check("err_count after relock", 32'(err_count), 32'd2);

        // One-cycle reset mid-frame while locked.
        gen_line(0, H_TOTAL, H_SYNC, 1'b1);
        gen_line(1, H_TOTAL, H_SYNC, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid reset locked", 32'(locked), 32'd0);
        check("mid reset err_count", 32'(err_count), 32'd0);
        check("mid reset pix_valid", 32'(pix_valid), 32'd0);
        check("mid reset pix_x/y", 32'({pix_x, pix_y}), 32'd0);
        check("mid reset rgb", 32'({pix_r, pix_g, pix_b}), 32'd0);
        for (int v = 2; v < V_TOTAL; v++) gen_line(v, H_TOTAL, H_SYNC, 1'b0);
        check("locked after reset remainder", 32'(locked), 32'd0);
        gen_frame(1'b0, -1, H_TOTAL, H_SYNC);
        check("locked after post-reset verify", 32'(locked), 32'd0);
        gen_frame(1'b1, -1, H_TOTAL, H_SYNC);
        check("relocked after reset", 32'(locked), 32'd1);

        // Repeated locked-frame violations drive err_count into saturation.
        for (int i = 0; i < 260; i++) begin
            gen_frame(1'b1, 3, H_TOTAL + 1, H_SYNC);
            check($sformatf("saturation err_count iter %0d", i), 32'(err_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            gen_frame(1'b0, -1, H_TOTAL, H_SYNC);
        end
        check("final scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
